// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction is done as A + nine's-complement(B) + 1, so carry=1 means no borrow.
// Operands enter through a valid/ready handshake. The result, carry and
// invalid-digit flag leave through a second valid/ready handshake.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_op;
  logic [W-1:0]  b_op;
  logic          c_run;
  logic [CW-1:0] cnt;

  logic [W-1:0]      b_nines;
  logic [DIGITS-1:0] a_bad;
  logic [DIGITS-1:0] b_bad;

  // Per-digit nine's complement of B (wraps mod 16 for illegal digits) and range flags
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign b_nines[4*gi +: 4] = 4'd9 - b[4*gi +: 4];
      assign a_bad[gi]          = (a[4*gi +: 4] > 4'd9);
      assign b_bad[gi]          = (b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  logic [3:0] a_dig;
  logic [3:0] b_dig;

  // Select the operand digits addressed by the digit counter
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        a_dig = a_op[4*i +: 4];
        b_dig = b_op[4*i +: 4];
      end
    end
  end

  logic [4:0] t;
  logic [3:0] digit;
  logic       c_out;

  // One decimal digit step: binary add, then +6 correction when the sum exceeds 9
  always_comb begin
    t = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, c_run};
    if (t > 5'd9) begin
      digit = t[3:0] + 4'd6;
      c_out = 1'b1;
    end else begin
      digit = t[3:0];
      c_out = 1'b0;
    end
  end

  logic last_digit;
  assign last_digit = (cnt == CW'(DIGITS - 1));

  // Control FSM with all outputs registered; DONE raises out_valid one cycle after entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      err       <= 1'b0;
      a_op      <= '0;
      b_op      <= '0;
      c_run     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_op     <= a;
            b_op     <= sub ? b_nines : b;
            c_run    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            sum      <= '0;
            err      <= |{a_bad, b_bad};
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) begin
              sum[4*i +: 4] <= digit;
            end
          end
          c_run <= c_out;
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            carry <= c_out;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Testbench for bcd_serial_addsub: directed cases plus randomized legal operations,
// checked against a decimal-arithmetic reference model.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         err;

  int tests = 0;
  int fails = 0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r;
    longint       m;
    r = '0;
    m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic; subtraction is A - B + 10^DIGITS
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, output logic [W-1:0] esum, output logic ecarry);
    longint m;
    longint r;
    m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    if (tsub) r = bcd2int(ta) + (m - bcd2int(tb));
    else      r = bcd2int(ta) + bcd2int(tb) + longint'(tcin);
    ecarry = (r >= m);
    esum   = int2bcd(r % m);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One full operation: handshake, latency, result, optional DONE stall, release
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input bit chk_val,
                        input logic exp_err, input int hold);
    logic [W-1:0] esum;
    logic         ecarry;
    int           k;
    int           lat;
    model(ta, tb, tcin, tsub, esum, ecarry);
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(DIGITS + 1));
    if (chk_val) begin
      check({name, "_sum"}, 64'(sum), 64'(esum));
      check({name, "_carry"}, 64'(carry), 64'(ecarry));
    end
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      if (chk_val) begin
        check({name, "_hold_sum"}, 64'(sum), 64'(esum));
        check({name, "_hold_carry"}, 64'(carry), 64'(ecarry));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release_valid"}, 64'(out_valid), 64'd0);
    check({name, "_release_in_ready"}, 64'(in_ready), 64'd1);
    $display("[TB] op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h carry=%0d err=%0d", name,
             ta, tb, tcin, tsub, esum, ecarry, exp_err);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_carry", 64'(carry), 64'd0);
    check("reset_err", 64'(err), 64'd0);

    run_op("add_basic", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("add_wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("add_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_op("sub_pos", 16'h5000, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_op("sub_neg", 16'h1234, 16'h5000, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_op("sub_cin_ignored", 16'h5000, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run_op("sub_equal", 16'h4321, 16'h4321, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run_op("bad_digit", 16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_op("after_bad", 16'h0042, 16'h0058, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("stall", 16'h8765, 16'h4321, 1'b1, 1'b0, 1'b1, 1'b0, 10);

    // Reset in the second RUN cycle of an operation with an illegal digit
    a = 16'hFFFF; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_sum", 64'(sum), 64'd0);
    check("midrun_rst_carry", 64'(carry), 64'd0);
    check("midrun_rst_err", 64'(err), 64'd0);
    $display("[TB] op midrun_reset: state cleared");
    run_op("after_rst", 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op($sformatf("rand%0d", n), ra, rb, rc, rs, 1'b1, 1'b0, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
